// File: rtl/sisc_fetch_pkg.sv
// sisc_fetch_pkg: shared FSM state and queue entry types for the SISC fetch front end
package sisc_fetch_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int INSTR_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;
    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
    } entry_t;
endpackage

// File: rtl/sisc_fetch_q.sv
// sisc_fetch_q: synchronous circular FIFO (power-of-two DEPTH) with clear
//   clk/rst : clock, synchronous active-high reset
//   clear   : drop all entries (wins over push/pop)
//   push/din, pop/dout : write tail / consume head (dout is the head entry)
//   count/full/empty   : occupancy 0..DEPTH
module sisc_fetch_q
    import sisc_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rd];
    assign do_pop = pop && !empty;
    // a pop frees the slot the same cycle, so push+pop at full is legal
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + AW'(1);
            if (do_pop) rd <= rd + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr] <= din;
    always_ff @(posedge clk)
        if (!rst && !clear) assert (!(push && full && !do_pop));
endmodule

// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction-fetch front end with PC, imem req/gnt/rvalid port and prefetch queue
//   clk/rst                      : clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt  : request handshake, one outstanding request max
//   imem_rvalid/imem_rdata       : response word
//   br_taken/br_target           : redirect strobe and target
//   instr_valid/instr/instr_pc/instr_ready : head-of-queue handshake to control
//   halt                         : stop issuing new requests
// Define SISC_FETCH_BR_REL_EN to treat br_target as a signed offset from instr_pc+1.
module sisc_fetch
    import sisc_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               halt
);
    localparam int CW = $clog2(DEPTH) + 1;
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } q_entry_t;
    state_t state;
    logic [ADDR_W-1:0] pc, req_pc, target;
    q_entry_t head, din;
    logic [CW-1:0] count;
    logic full, empty, redirect, pop, push, wait_room;
`ifdef SISC_FETCH_BR_REL_EN
    assign redirect = br_taken && instr_valid;
    assign target = instr_pc + ADDR_W'(1) + br_target;
`else
    assign redirect = br_taken;
    assign target = br_target;
`endif
    assign instr_valid = !empty;
    assign instr = head.instr;
    assign instr_pc = head.pc;
    assign imem_req = state == REQ;
    assign imem_addr = pc;
    assign pop = instr_valid && instr_ready;
    assign push = state == WAIT && imem_rvalid && !redirect;
    assign din = {imem_rdata, req_pc};
    // room for another request once this cycle's push/pop settle
    assign wait_room = count - CW'(pop) < CW'(DEPTH - 1);
    sisc_fetch_q #(.DEPTH(DEPTH), .W(INSTR_W + ADDR_W)) u_q (
        .clk(clk),
        .rst(rst),
        .clear(redirect),
        .push(push),
        .pop(pop),
        .din(din),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
            // a still-pending response must be swallowed before refetching
            state <= (state == REQ && imem_gnt) || (state inside {WAIT, FLUSH} && !imem_rvalid) ? FLUSH :
                     (state == REQ || !halt) ? REQ : IDLE;
        end else begin
            case (state)
                IDLE:  if (!halt && !full) state <= REQ;
                REQ:   if (imem_gnt) begin
                    state <= WAIT;
                    req_pc <= pc;
                    pc <= pc + ADDR_W'(1);
                end
                WAIT:  if (imem_rvalid) state <= (!halt && wait_room) ? REQ : IDLE;
                FLUSH: if (imem_rvalid) state <= halt ? IDLE : REQ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
